vga_io_regs: RTL and testbench

Processor-facing register bank that feeds the `vga` display block, sitting between the processor's memory-mapped I/O bus and `vga`. It holds shadow copies of the four player scores, the display value, screen status and winner. It commits all of them to its outputs atomically on the falling edge of `vsync`, so a frame never shows a half-updated scoreboard. It also debounces the four raw player buttons, drives the debounced levels to `vga`, and exposes sticky press flags plus an interrupt to the processor.

---
 rtl/vga_io_regs_pkg.sv | 46 ++++
 rtl/vga_io_regs_if.sv | 13 +
 rtl/vga_io_regs_btn_debounce.sv | 42 ++++
 rtl/vga_io_regs.sv | 140 ++++++++++++++
 tb/tb_vga_io_regs.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_io_regs_pkg.sv
// Shared constants and payload types for the vga_io_regs register bank.
package vga_io_pkg;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned SCORE_W  = 16;
    localparam int unsigned VALUE_W  = 8;
    localparam int unsigned STATUS_W = 2;
    localparam int unsigned WINNER_W = 2;
    localparam int unsigned NUM_BTN  = 4;

    localparam logic [ADDR_W-1:0] ADDR_P1     = 4'd0;
    localparam logic [ADDR_W-1:0] ADDR_P2     = 4'd1;
    localparam logic [ADDR_W-1:0] ADDR_P3     = 4'd2;
    localparam logic [ADDR_W-1:0] ADDR_P4     = 4'd3;
    localparam logic [ADDR_W-1:0] ADDR_VALUE  = 4'd4;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'd5;
    localparam logic [ADDR_W-1:0] ADDR_COMMIT = 4'd6;
    localparam logic [ADDR_W-1:0] ADDR_BTN    = 4'd7;
    localparam logic [ADDR_W-1:0] ADDR_IRQEN  = 4'd8;

    localparam int unsigned CTRL_STATUS_LSB = 0;
    localparam int unsigned CTRL_WINNER_LSB = 2;
    localparam int unsigned BTN_STICKY_LSB  = 4;

    // Everything the display consumes; committed as one unit on vsync fall.
    typedef struct packed {
        logic [SCORE_W-1:0]  p1;
        logic [SCORE_W-1:0]  p2;
        logic [SCORE_W-1:0]  p3;
        logic [SCORE_W-1:0]  p4;
        logic [VALUE_W-1:0]  value;
        logic [STATUS_W-1:0] status;
        logic [WINNER_W-1:0] winner;
    } disp_regs_t;

    function automatic logic [DATA_W-1:0] ctrl_word(input logic [STATUS_W-1:0] status,
                                                    input logic [WINNER_W-1:0] winner);
        logic [DATA_W-1:0] w;
        w = '0;
        w[CTRL_STATUS_LSB +: STATUS_W] = status;
        w[CTRL_WINNER_LSB +: WINNER_W] = winner;
        return w;
    endfunction

endpackage

// File: rtl/vga_io_regs_if.sv
// Processor memory-mapped bus between the CPU and the vga_io_regs bank.
interface vga_io_regs_if;
    import vga_io_pkg::*;

    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output we, output re, output addr, output wdata, input rdata);
    modport slave  (input we, input re, input addr, input wdata, output rdata);
endinterface

// File: rtl/vga_io_regs_btn_debounce.sv
// One button: 2-flop synchronizer, mismatch counter and debounced level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise_c
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             flip_c;

    // Flip happens on the edge where the mismatch has lasted DEBOUNCE_CYCLES cycles.
    assign flip_c = (s != level) && (cnt == CNT_MAX);
    assign rise_c = flip_c & ~level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            s     <= sync1;
            if (s == level) begin
                cnt <= '0;
            end else if (flip_c) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/vga_io_regs.sv
// Register bank feeding the vga block: shadow scores committed on vsync fall,
// debounced player buttons with sticky press flags and a level interrupt.
module vga_io_regs
    import vga_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    vga_io_regs_if.slave        bus,
    input  logic [NUM_BTN-1:0]  btn_raw,
    input  logic                vsync,
    output logic [SCORE_W-1:0]  p1,
    output logic [SCORE_W-1:0]  p2,
    output logic [SCORE_W-1:0]  p3,
    output logic [SCORE_W-1:0]  p4,
    output logic [VALUE_W-1:0]  value,
    output logic [STATUS_W-1:0] screenStatus,
    output logic [WINNER_W-1:0] winnerPlayerNum,
    output logic                p1Btn,
    output logic                p2Btn,
    output logic                p3Btn,
    output logic                p4Btn,
    output logic                irq
);
    disp_regs_t         shadow;
    disp_regs_t         shadow_d;
    disp_regs_t         shown;
    logic               pending;
    logic               vsync_q;
    logic [NUM_BTN-1:0] sticky;
    logic [NUM_BTN-1:0] sticky_d;
    logic [NUM_BTN-1:0] irq_en;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise_c;
    logic               vsync_fall_c;
    logic               commit_wr_c;
    logic               btn_wr_c;
    logic               irqen_wr_c;
    logic [DATA_W-1:0]  rd_mux_c;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[i]),
            .level  (level[i]),
            .rise_c (rise_c[i])
        );
    end

    assign vsync_fall_c = vsync_q & ~vsync;
    assign commit_wr_c  = bus.we && (bus.addr == ADDR_COMMIT);
    assign btn_wr_c     = bus.we && (bus.addr == ADDR_BTN);
    assign irqen_wr_c   = bus.we && (bus.addr == ADDR_IRQEN);

    // Shadow write decode.
    always_comb begin
        shadow_d = shadow;
        if (bus.we) begin
            unique case (bus.addr)
                ADDR_P1:    shadow_d.p1 = bus.wdata;
                ADDR_P2:    shadow_d.p2 = bus.wdata;
                ADDR_P3:    shadow_d.p3 = bus.wdata;
                ADDR_P4:    shadow_d.p4 = bus.wdata;
                ADDR_VALUE: shadow_d.value = bus.wdata[VALUE_W-1:0];
                ADDR_CTRL: begin
                    shadow_d.status = bus.wdata[CTRL_STATUS_LSB +: STATUS_W];
                    shadow_d.winner = bus.wdata[CTRL_WINNER_LSB +: WINNER_W];
                end
                default: ;
            endcase
        end
    end

    // A new press wins over a same-cycle clear of the same flag.
    always_comb begin
        sticky_d = sticky;
        if (btn_wr_c) begin
            sticky_d = sticky & ~bus.wdata[BTN_STICKY_LSB +: NUM_BTN];
        end
        sticky_d = sticky_d | rise_c;
    end

    always_comb begin
        rd_mux_c = '0;
        unique case (bus.addr)
            ADDR_P1:     rd_mux_c = shadow.p1;
            ADDR_P2:     rd_mux_c = shadow.p2;
            ADDR_P3:     rd_mux_c = shadow.p3;
            ADDR_P4:     rd_mux_c = shadow.p4;
            ADDR_VALUE:  rd_mux_c = DATA_W'(shadow.value);
            ADDR_CTRL:   rd_mux_c = ctrl_word(shadow.status, shadow.winner);
            ADDR_COMMIT: rd_mux_c = DATA_W'(pending);
            ADDR_BTN:    rd_mux_c = DATA_W'({sticky, level});
            ADDR_IRQEN:  rd_mux_c = DATA_W'(irq_en);
            default:     rd_mux_c = '0;
        endcase
    end

    // Commit copies the pre-write shadow since shadow updates on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            shown     <= '0;
            pending   <= 1'b0;
            vsync_q   <= 1'b1;
            sticky    <= '0;
            irq_en    <= '0;
            bus.rdata <= '0;
        end else begin
            shadow  <= shadow_d;
            vsync_q <= vsync;
            if (vsync_fall_c && pending) begin
                shown <= shadow;
            end
            pending <= commit_wr_c | (pending & ~vsync_fall_c);
            sticky  <= sticky_d;
            if (irqen_wr_c) begin
                irq_en <= bus.wdata[NUM_BTN-1:0];
            end
            if (bus.re) begin
                bus.rdata <= rd_mux_c;
            end
        end
    end

    assign p1              = shown.p1;
    assign p2              = shown.p2;
    assign p3              = shown.p3;
    assign p4              = shown.p4;
    assign value           = shown.value;
    assign screenStatus    = shown.status;
    assign winnerPlayerNum = shown.winner;
    assign p1Btn           = level[0];
    assign p2Btn           = level[1];
    assign p3Btn           = level[2];
    assign p4Btn           = level[3];
    assign irq             = |(sticky & irq_en);
endmodule

// File: tb/tb_vga_io_regs.sv
// Directed bench for vga_io_regs with DEBOUNCE_CYCLES=4.
module tb_vga_io_regs;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn_raw;
    logic        vsync;
    logic [15:0] p1, p2, p3, p4;
    logic [7:0]  value;
    logic [1:0]  screenStatus, winnerPlayerNum;
    logic        p1Btn, p2Btn, p3Btn, p4Btn, irq;
    logic [15:0] rd_val;
    int          checks = 0;
    int          failures = 0;

    vga_io_regs_if bus();

    vga_io_regs #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .btn_raw(btn_raw), .vsync(vsync),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .value(value),
        .screenStatus(screenStatus), .winnerPlayerNum(winnerPlayerNum),
        .p1Btn(p1Btn), .p2Btn(p2Btn), .p3Btn(p3Btn), .p4Btn(p4Btn), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        tick();
        bus.we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        bus.re = 1'b1; bus.addr = a;
        tick();
        bus.re = 1'b0;
        d = bus.rdata;
    endtask

    initial begin
        rst = 1'b1; btn_raw = 4'h0; vsync = 1'b1;
        bus.we = 1'b0; bus.re = 1'b0; bus.addr = 4'h0; bus.wdata = 16'h0;
        repeat (3) tick();
        chk("reset_p1", p1, 16'h0);
        chk("reset_status", 16'(screenStatus), 16'h0);
        chk("reset_irq", 16'(irq), 16'h0);
        chk("reset_rdata", bus.rdata, 16'h0);
        chk("reset_btns", 16'({p4Btn, p3Btn, p2Btn, p1Btn}), 16'h0);
        rst = 1'b0;
        tick();

        // Basic commit
        wr(4'd0, 16'h0012);
        wr(4'd5, 16'h0006);
        wr(4'd6, 16'h0001);
        repeat (10) tick();
        chk("precommit_p1", p1, 16'h0);
        chk("precommit_status", 16'(screenStatus), 16'h0);
        rd(4'd6, rd_val);
        chk("pending_set", rd_val, 16'h1);
        vsync = 1'b0;
        tick();
        chk("commit_p1", p1, 16'h0012);
        chk("commit_status", 16'(screenStatus), 16'h2);
        chk("commit_winner", 16'(winnerPlayerNum), 16'h1);
        rd(4'd6, rd_val);
        chk("pending_clear", rd_val, 16'h0);
        vsync = 1'b1;
        tick();

        // Write racing with vsync fall commits the old shadow
        wr(4'd1, 16'h0011);
        wr(4'd6, 16'h0001);
        vsync = 1'b0; bus.we = 1'b1; bus.addr = 4'd1; bus.wdata = 16'h0055;
        tick();
        bus.we = 1'b0; vsync = 1'b1;
        tick();
        chk("race_p2_old", p2, 16'h0011);
        rd(4'd1, rd_val);
        chk("race_p2_shadow", rd_val, 16'h0055);
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        chk("race_no_pending", p2, 16'h0011);
        tick();
        wr(4'd6, 16'h0001);
        vsync = 1'b0;
        tick();
        chk("race_p2_new", p2, 16'h0055);
        vsync = 1'b1;
        tick();

        // COMMIT write coincident with vsync fall re-arms pending
        wr(4'd6, 16'h0001);
        vsync = 1'b0; bus.we = 1'b1; bus.addr = 4'd6; bus.wdata = 16'h0001;
        tick();
        bus.we = 1'b0; vsync = 1'b1;
        rd(4'd6, rd_val);
        chk("commit_rearm", rd_val, 16'h1);
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        rd(4'd6, rd_val);
        chk("commit_rearm_done", rd_val, 16'h0);

        // Glitch shorter than the debounce window
        btn_raw = 4'h4;
        repeat (3) tick();
        btn_raw = 4'h0;
        repeat (8) tick();
        chk("glitch_p3btn", 16'(p3Btn), 16'h0);
        rd(4'd7, rd_val);
        chk("glitch_btn_reg", rd_val, 16'h0);

        // Held press: level flips 5 edges after the first sample
        btn_raw = 4'h4;
        repeat (5) tick();
        chk("press_early", 16'(p3Btn), 16'h0);
        tick();
        chk("press_level", 16'(p3Btn), 16'h1);
        chk("press_irq_masked", 16'(irq), 16'h0);
        repeat (4) tick();
        rd(4'd7, rd_val);
        chk("press_btn_reg", rd_val, 16'h0044);
        wr(4'd8, 16'h0004);
        chk("irq_enabled", 16'(irq), 16'h1);
        wr(4'd7, 16'h0040);
        chk("irq_w1c", 16'(irq), 16'h0);
        chk("w1c_level_kept", 16'(p3Btn), 16'h1);
        rd(4'd7, rd_val);
        chk("w1c_btn_reg", rd_val, 16'h0004);
        btn_raw = 4'h0;
        repeat (10) tick();
        chk("release_level", 16'(p3Btn), 16'h0);
        chk("release_no_irq", 16'(irq), 16'h0);

        // W1C coincident with a new rise: set wins
        btn_raw = 4'h4;
        repeat (5) tick();
        wr(4'd7, 16'h0040);
        chk("race_rise_level", 16'(p3Btn), 16'h1);
        chk("race_rise_irq", 16'(irq), 16'h1);
        rd(4'd7, rd_val);
        chk("race_rise_btn_reg", rd_val, 16'h0044);
        wr(4'd7, 16'h0040);
        chk("race_rise_clear", 16'(irq), 16'h0);
        btn_raw = 4'h0;
        repeat (10) tick();

        // Register map corners
        wr(4'd4, 16'h01AB);
        rd(4'd4, rd_val);
        chk("value_masked", rd_val, 16'h00AB);
        tick();
        chk("rdata_hold", bus.rdata, 16'h00AB);
        rd(4'd5, rd_val);
        chk("ctrl_read", rd_val, 16'h0006);
        rd(4'd8, rd_val);
        chk("irqen_read", rd_val, 16'h0004);
        wr(4'd12, 16'hFFFF);
        rd(4'd12, rd_val);
        chk("unmapped_read", rd_val, 16'h0000);
        bus.we = 1'b1; bus.re = 1'b1; bus.addr = 4'd0; bus.wdata = 16'h0077;
        tick();
        bus.we = 1'b0; bus.re = 1'b0;
        chk("rw_same_cycle", bus.rdata, 16'h0012);
        rd(4'd0, rd_val);
        chk("rw_written", rd_val, 16'h0077);

        // Reset mid-debounce with a commit pending
        wr(4'd6, 16'h0001);
        btn_raw = 4'h1;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("rst_p1", p1, 16'h0);
        chk("rst_p2", p2, 16'h0);
        chk("rst_status", 16'(screenStatus), 16'h0);
        chk("rst_rdata", bus.rdata, 16'h0);
        tick();
        rst = 1'b0; btn_raw = 4'h0;
        vsync = 1'b0;
        tick();
        chk("rst_no_commit", p1, 16'h0);
        vsync = 1'b1;
        repeat (6) tick();
        chk("rst_p1btn", 16'(p1Btn), 16'h0);
        rd(4'd6, rd_val);
        chk("rst_pending", rd_val, 16'h0);
        rd(4'd0, rd_val);
        chk("rst_shadow", rd_val, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
